systolic_mm_engine: RTL and testbench

Parametrised output-stationary matrix-multiply engine, successor to the fixed-size MAC grid. Computes C[ROWS×COLS] = Σₖ A[:,k]·B[k,:] over a caller-chosen depth K. Adds over the plain grid:

- internal operand skewing
- a job-control FSM with valid/ready handshakes
- optional accumulate-across-jobs
- saturating or wrapping arithmetic with an overflow flag
- row-by-row result readout

Sits between the operand buffers and the result writeback path.

---
 rtl/systolic_mm_engine.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_engine.sv
// -----------------------------------------------------------------------------
// systolic_mm_engine
//
// Output-stationary matrix-multiply engine. Each job streams k_len operand
// beats (column k of A, row k of B) into a ROWS x COLS grid of MAC cells.
// The engine then drains the pipeline and presents C one row per handshake.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start, k_len,       job request (taken only in IDLE); beat count and
//   accum_mode          "keep previous accumulators" flag captured with it
//   in_valid/in_ready   operand beat handshake (in_ready only while loading)
//   a_vec, b_vec        unskewed operand vectors, element i at [i*BITS_AB +:]
//   out_valid/out_ready result row handshake
//   out_row             C[out_row_idx][*], element j at [j*BITS_C +:]
//   out_row_idx         row being presented
//   out_last            marks the final row
//   busy                job in progress
//   ovf_flag            sticky accumulator overflow for the current job
// -----------------------------------------------------------------------------
module systolic_mm_engine #(
    parameter int BITS_AB  = 8,
    parameter int BITS_C   = 16,
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int SATURATE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 k_len,
    input  logic                       accum_mode,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*BITS_AB-1:0]    a_vec,
    input  logic [COLS*BITS_AB-1:0]    b_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLS*BITS_C-1:0]     out_row,
    output logic [$clog2(ROWS)-1:0]    out_row_idx,
    output logic                       out_last,
    output logic                       busy,
    output logic                       ovf_flag
);

    localparam int IDX_W      = $clog2(ROWS);
    localparam int DW         = $clog2(ROWS + COLS);
    // Last PE accumulates ROWS+COLS-1 edges after the final beat; the drain
    // counter therefore runs 0..ROWS+COLS-2.
    localparam int DRAIN_LAST = ROWS + COLS - 2;
    localparam logic [BITS_C-1:0] ACC_MAX = {1'b0, {(BITS_C-1){1'b1}}};
    localparam logic [BITS_C-1:0] ACC_MIN = {1'b1, {(BITS_C-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, READ} state_t;

    state_t                     state_reg;
    logic [7:0]                 k_len_reg;
    logic [7:0]                 beat_cnt_reg;
    logic [DW-1:0]              drain_cnt_reg;
    logic                       in_ready_reg;
    logic                       busy_reg;
    logic                       out_valid_reg;
    logic                       out_last_reg;
    logic [IDX_W-1:0]           out_row_idx_reg;
    logic [COLS*BITS_C-1:0]     out_row_reg;
    logic                       ovf_flag_reg;

    logic                       beat_acc;
    logic                       start_acc;
    logic                       clr_acc;
    logic [IDX_W-1:0]           idx_next;

    // Skew outputs: row i / column j delayed by i / j cycles.
    logic signed [BITS_AB-1:0]  a_sk_val [ROWS];
    logic                       a_sk_vld [ROWS];
    logic signed [BITS_AB-1:0]  b_sk_val [COLS];

    // Token held at each PE's input; A moves right, B moves down.
    logic signed [BITS_AB-1:0]  a_tok_val [ROWS][COLS];
    logic                       a_tok_vld [ROWS][COLS];
    logic signed [BITS_AB-1:0]  b_tok_val [ROWS][COLS];

    logic signed [BITS_C-1:0]   acc_reg  [ROWS][COLS];
    logic signed [BITS_C-1:0]   acc_next [ROWS][COLS];
    logic [ROWS*COLS-1:0]       pe_ovf;

    assign beat_acc  = in_valid && in_ready_reg;
    assign start_acc = (state_reg == IDLE) && start;
    assign clr_acc   = start_acc && !accum_mode;
    assign idx_next  = out_row_idx_reg + IDX_W'(1);

    // -------------------------------------------------------------------------
    // Input skew. Only A tracks a valid bit: A and B tokens of one beat always
    // meet at the same PE on the same edge, so B's valid would be redundant.
    // -------------------------------------------------------------------------
    genvar gi, gj;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_a_skew
            if (gi == 0) begin : g_direct
                assign a_sk_val[gi] = a_vec[gi*BITS_AB +: BITS_AB];
                assign a_sk_vld[gi] = beat_acc;
            end else begin : g_delay
                logic signed [BITS_AB-1:0] val_reg [gi];
                logic                      vld_reg [gi];
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int s = 0; s < gi; s++) begin
                            val_reg[s] <= '0;
                            vld_reg[s] <= 1'b0;
                        end
                    end else begin
                        val_reg[0] <= a_vec[gi*BITS_AB +: BITS_AB];
                        vld_reg[0] <= beat_acc;
                        for (int s = 1; s < gi; s++) begin
                            val_reg[s] <= val_reg[s-1];
                            vld_reg[s] <= vld_reg[s-1];
                        end
                    end
                end
                assign a_sk_val[gi] = val_reg[gi-1];
                assign a_sk_vld[gi] = vld_reg[gi-1];
            end
        end

        for (gj = 0; gj < COLS; gj++) begin : g_b_skew
            if (gj == 0) begin : g_direct
                assign b_sk_val[gj] = b_vec[gj*BITS_AB +: BITS_AB];
            end else begin : g_delay
                logic signed [BITS_AB-1:0] val_reg [gj];
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int s = 0; s < gj; s++) val_reg[s] <= '0;
                    end else begin
                        val_reg[0] <= b_vec[gj*BITS_AB +: BITS_AB];
                        for (int s = 1; s < gj; s++) val_reg[s] <= val_reg[s-1];
                    end
                end
                assign b_sk_val[gj] = val_reg[gj-1];
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Token pipeline: advances every cycle, bubbles travel as invalid tokens.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    a_tok_val[i][j] <= '0;
                    a_tok_vld[i][j] <= 1'b0;
                    b_tok_val[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                a_tok_val[i][0] <= a_sk_val[i];
                a_tok_vld[i][0] <= a_sk_vld[i];
                for (int j = 1; j < COLS; j++) begin
                    a_tok_val[i][j] <= a_tok_val[i][j-1];
                    a_tok_vld[i][j] <= a_tok_vld[i][j-1];
                end
            end
            for (int j = 0; j < COLS; j++) begin
                b_tok_val[0][j] <= b_sk_val[j];
                for (int i = 1; i < ROWS; i++) begin
                    b_tok_val[i][j] <= b_tok_val[i-1][j];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // PE arithmetic: one extra sum bit exposes signed overflow directly.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                logic signed [2*BITS_AB-1:0] prod;
                logic signed [BITS_C-1:0]    prod_c;
                logic        [BITS_C:0]      sum_w;
                logic                        ovf;

                assign prod = (2*BITS_AB)'(a_tok_val[gi][gj]) * (2*BITS_AB)'(b_tok_val[gi][gj]);

                if (BITS_C >= 2*BITS_AB) begin : g_ext
                    assign prod_c = BITS_C'(prod);
                end else begin : g_trunc
                    assign prod_c = prod[BITS_C-1:0];
                end

                assign sum_w = {acc_reg[gi][gj][BITS_C-1], acc_reg[gi][gj]}
                             + {prod_c[BITS_C-1], prod_c};
                assign ovf   = sum_w[BITS_C] ^ sum_w[BITS_C-1];
                assign pe_ovf[gi*COLS + gj] = ovf && a_tok_vld[gi][gj];

                if (SATURATE != 0) begin : g_sat
                    // sum_w[BITS_C] is the true sign of the unbounded sum.
                    assign acc_next[gi][gj] = ovf ? (sum_w[BITS_C] ? ACC_MIN : ACC_MAX)
                                                  : sum_w[BITS_C-1:0];
                end else begin : g_wrap
                    assign acc_next[gi][gj] = sum_w[BITS_C-1:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    acc_reg[i][j] <= '0;
        end else if (clr_acc) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    acc_reg[i][j] <= '0;
        end else begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    if (a_tok_vld[i][j]) acc_reg[i][j] <= acc_next[i][j];
        end
    end

    // -------------------------------------------------------------------------
    // Job control and result readout.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            k_len_reg       <= '0;
            beat_cnt_reg    <= '0;
            drain_cnt_reg   <= '0;
            in_ready_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_last_reg    <= 1'b0;
            out_row_idx_reg <= '0;
            out_row_reg     <= '0;
            ovf_flag_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy_reg     <= 1'b1;
                        k_len_reg    <= k_len;
                        beat_cnt_reg <= '0;
                        if (k_len == 8'd0) begin
                            state_reg <= READ;
                        end else begin
                            state_reg    <= LOAD;
                            in_ready_reg <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (beat_acc) begin
                        beat_cnt_reg <= beat_cnt_reg + 8'd1;
                        if (beat_cnt_reg + 8'd1 == k_len_reg) begin
                            state_reg     <= DRAIN;
                            in_ready_reg  <= 1'b0;
                            drain_cnt_reg <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt_reg == DW'(DRAIN_LAST)) begin
                        state_reg <= READ;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + DW'(1);
                    end
                end
                READ: begin
                    if (!out_valid_reg) begin
                        // First row: accumulators settled on the previous edge.
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= 1'b0;   // ROWS >= 2, row 0 is never last
                        for (int j = 0; j < COLS; j++)
                            out_row_reg[j*BITS_C +: BITS_C] <= acc_reg[out_row_idx_reg][j];
                    end else if (out_ready) begin
                        if (out_last_reg) begin
                            state_reg       <= IDLE;
                            out_valid_reg   <= 1'b0;
                            out_last_reg    <= 1'b0;
                            out_row_idx_reg <= '0;
                            busy_reg        <= 1'b0;
                        end else begin
                            out_row_idx_reg <= idx_next;
                            out_last_reg    <= (idx_next == IDX_W'(ROWS-1));
                            for (int j = 0; j < COLS; j++)
                                out_row_reg[j*BITS_C +: BITS_C] <= acc_reg[idx_next][j];
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (start_acc) begin
                ovf_flag_reg <= 1'b0;
            end else if (|pe_ovf) begin
                ovf_flag_reg <= 1'b1;
            end
        end
    end

    assign in_ready    = in_ready_reg;
    assign busy        = busy_reg;
    assign out_valid   = out_valid_reg;
    assign out_last    = out_last_reg;
    assign out_row_idx = out_row_idx_reg;
    assign out_row     = out_row_reg;
    assign ovf_flag    = ovf_flag_reg;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// -----------------------------------------------------------------------------
// Bench for systolic_mm_engine: a saturating and a wrapping instance (4x4,
// 8-bit operands, 16-bit results) share all inputs. Jobs come from a table of
// operand patterns with hand-computed results; bubbles, backpressure, reset
// mid-load and ignored starts are driven as explicit sequences.
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_systolic_mm_engine;

    localparam int BITS_AB = 8;
    localparam int BITS_C  = 16;
    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int RW      = COLS * BITS_C;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [7:0]              k_len = '0;
    logic                    accum_mode = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    out_ready = 1'b0;
    logic [ROWS*BITS_AB-1:0] a_vec = '0;
    logic [COLS*BITS_AB-1:0] b_vec = '0;

    logic          s_in_ready, s_out_valid, s_out_last, s_busy, s_ovf;
    logic [RW-1:0] s_out_row;
    logic [1:0]    s_out_row_idx;
    logic          w_in_ready, w_out_valid, w_out_last, w_busy, w_ovf;
    logic [RW-1:0] w_out_row;
    logic [1:0]    w_out_row_idx;

    systolic_mm_engine #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .ROWS(ROWS), .COLS(COLS), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .accum_mode(accum_mode),
        .in_valid(in_valid), .in_ready(s_in_ready), .a_vec(a_vec), .b_vec(b_vec),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_row(s_out_row),
        .out_row_idx(s_out_row_idx), .out_last(s_out_last), .busy(s_busy), .ovf_flag(s_ovf)
    );

    systolic_mm_engine #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .ROWS(ROWS), .COLS(COLS), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .accum_mode(accum_mode),
        .in_valid(in_valid), .in_ready(w_in_ready), .a_vec(a_vec), .b_vec(b_vec),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_row(w_out_row),
        .out_row_idx(w_out_row_idx), .out_last(w_out_last), .busy(w_busy), .ovf_flag(w_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int job_id   = 0;

    typedef struct {
        int k;          // beats
        bit accum;      // accum_mode
        bit a_ident;    // 1: A = identity, else every a = a_c
        int a_c;
        bit b_ramp;     // 1: b[k][j] = 4k+j, else every b = b_c
        int b_c;
        bit exp_ramp;   // 1: C[r][j] = 4r+j, else every element constant
        int exp_sat;
        int exp_wrap;
        bit exp_ovf;
        bit gaps;       // in_valid pattern 1,0,0,1,...
        int stall_row;  // row held with out_ready low for 3 cycles (-1 none)
        bit poke;       // stray start pulses during DRAIN and READ
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL job%0d %s: got %0h expected %0h", job_id, name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] exp_row(input vec_t v, input int r, input bit sat);
        logic [RW-1:0] row;
        int e;
        row = '0;
        for (int j = 0; j < COLS; j++) begin
            e = v.exp_ramp ? (4*r + j) : (sat ? v.exp_sat : v.exp_wrap);
            row[j*BITS_C +: BITS_C] = BITS_C'(e);
        end
        return row;
    endfunction

    task automatic drive_beat(input vec_t v, input int beat);
        for (int i = 0; i < ROWS; i++)
            a_vec[i*BITS_AB +: BITS_AB] = v.a_ident ? ((i == beat) ? 8'd1 : 8'd0) : 8'(v.a_c);
        for (int j = 0; j < COLS; j++)
            b_vec[j*BITS_AB +: BITS_AB] = v.b_ramp ? 8'(4*beat + j) : 8'(v.b_c);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready",  {63'd0, s_in_ready},  64'd0);
        check("rst_out_valid", {63'd0, s_out_valid}, 64'd0);
        check("rst_busy",      {63'd0, s_busy},      64'd0);
        check("rst_ovf",       {63'd0, s_ovf},       64'd0);
        check("rst_out_row",   s_out_row,            64'd0);
        check("rst_row_idx",   {62'd0, s_out_row_idx}, 64'd0);
        check("rst_out_last",  {63'd0, s_out_last},  64'd0);
        check("rst_w_out_valid", {63'd0, w_out_valid}, 64'd0);
        check("rst_w_busy",      {63'd0, w_busy},      64'd0);
        check("rst_w_out_row",   w_out_row,            64'd0);
    endtask

    task automatic run_job(input vec_t v);
        int beat, phase, budget, last_edge, start_edge, exp_first;
        logic [RW-1:0] exp_s, exp_w;

        // Start, with a junk beat offered in the same cycle; it must be ignored.
        @(negedge clk);
        start = 1'b1; k_len = 8'(v.k); accum_mode = v.accum;
        in_valid = 1'b1; a_vec = $urandom; b_vec = $urandom;
        start_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        check("busy_after_start", {63'd0, s_busy}, 64'd1);
        check("in_ready_after_start", {63'd0, s_in_ready}, (v.k != 0) ? 64'd1 : 64'd0);

        beat = 0; phase = 0; budget = 0; last_edge = start_edge;
        while (beat < v.k && budget < 2000) begin
            if (!v.gaps || (phase % 3) == 0) begin
                in_valid = 1'b1;
                drive_beat(v, beat);
            end else begin
                in_valid = 1'b0;
                a_vec = $urandom; b_vec = $urandom;
            end
            if (in_valid && s_in_ready) begin
                last_edge = cyc + 1;
                beat++;
            end
            phase++; budget++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("beats_accepted", 64'(beat), 64'(v.k));

        if (v.poke) begin
            // Engine is in DRAIN here; a clearing start must have no effect.
            check("in_ready_drain", {63'd0, s_in_ready}, 64'd0);
            start = 1'b1; k_len = 8'd0; accum_mode = 1'b0;
            @(negedge clk);
            start = 1'b0;
        end

        budget = 0;
        while (!s_out_valid && budget < 600) begin
            @(negedge clk);
            budget++;
        end
        exp_first = (v.k == 0) ? start_edge + 1 : last_edge + ROWS + COLS;
        check("first_valid_edge", 64'(cyc), 64'(exp_first));

        for (int r = 0; r < ROWS; r++) begin
            budget = 0;
            while (!s_out_valid && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            exp_s = exp_row(v, r, 1'b1);
            exp_w = exp_row(v, r, 1'b0);
            check($sformatf("row%0d_idx", r), {62'd0, s_out_row_idx}, 64'(r));
            check($sformatf("row%0d_last", r), {63'd0, s_out_last}, (r == ROWS-1) ? 64'd1 : 64'd0);
            check($sformatf("row%0d_sat", r), s_out_row, exp_s);
            check($sformatf("row%0d_wrap", r), w_out_row, exp_w);
            if (r == 0) begin
                check("ovf_sat",  {63'd0, s_ovf}, {63'd0, v.exp_ovf});
                check("ovf_wrap", {63'd0, w_ovf}, {63'd0, v.exp_ovf});
                if (v.poke) begin
                    start = 1'b1; k_len = 8'd0; accum_mode = 1'b0;
                end
            end
            if (r == v.stall_row) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    start = 1'b0;
                    check($sformatf("stall%0d_valid", s), {63'd0, s_out_valid}, 64'd1);
                    check($sformatf("stall%0d_idx", s), {62'd0, s_out_row_idx}, 64'(r));
                    check($sformatf("stall%0d_row", s), s_out_row, exp_s);
                    check($sformatf("stall%0d_wrow", s), w_out_row, exp_w);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            out_ready = 1'b0;
        end

        check("busy_after_read", {63'd0, s_busy}, 64'd0);
        check("valid_after_read", {63'd0, s_out_valid}, 64'd0);
        @(negedge clk);
        check("no_extra_row", {63'd0, s_out_valid | w_out_valid}, 64'd0);
        $display("job%0d done: k_len=%0d accum=%0d row0_sat=%0h row0_wrap=%0h",
                 job_id, v.k, v.accum, exp_row(v, 0, 1'b1), exp_row(v, 0, 1'b0));
        job_id++;
    endtask

    vec_t tbl [7];
    vec_t seq_v;

    initial begin
        //           k    acc ident a_c  ramp b_c  eramp e_sat  e_wrap  ovf gaps stall poke
        tbl[0] = '{  4,   0,  1,    0,   1,   0,   1,    0,     0,      0,  0,   -1,   0};
        tbl[1] = '{  2,   0,  0,    1,   0,   1,   0,    2,     2,      0,  0,   -1,   0};
        tbl[2] = '{  2,   1,  0,    1,   0,   1,   0,    4,     4,      0,  0,   -1,   0};
        tbl[3] = '{  0,   0,  0,    1,   0,   1,   0,    0,     0,      0,  0,   -1,   0};
        tbl[4] = '{  3,   0,  0,   -3,   0,   5,   0,  -45,   -45,      0,  0,   -1,   0};
        tbl[5] = '{  1,   0,  0, -128,   0,-128,   0, 16384, 16384,     0,  0,   -1,   0};
        // 127*127*255 = 4112895 = 62*65536 + 49663; 49663 - 65536 = -15873
        tbl[6] = '{255,   0,  0,  127,   0, 127,   0, 32767, -15873,    1,  0,   -1,   0};

        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;

        for (int n = 0; n < 7; n++) run_job(tbl[n]);

        // Identity again with bubbles on the input and a stalled row 1.
        seq_v = tbl[0];
        seq_v.gaps = 1'b1;
        seq_v.stall_row = 1;
        run_job(seq_v);

        // Abort an accumulating job after 3 of 8 beats with an async reset.
        @(negedge clk);
        start = 1'b1; k_len = 8'd8; accum_mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1; a_vec = {4{8'd5}}; b_vec = {4{8'd7}};
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        seq_v = '{8, 1, 0, 1, 0, 1, 0, 8, 8, 0, 0, -1, 0};
        run_job(seq_v);

        // Stray starts during DRAIN and READ must not disturb the job.
        seq_v = '{2, 0, 0, 1, 0, 1, 0, 2, 2, 0, 0, -1, 1};
        run_job(seq_v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
